// File: rtl/ir_blob_decoder_pkg.sv
// Shared definitions for the IR camera blob decoder: record layout, state encoding
// and the decoded-blob structure.
package ir_blob_decoder_pkg;

    localparam logic [9:0] INVALID_COORD = 10'h3FF;

    localparam logic [1:0] BLOB_X_LO = 2'd0;
    localparam logic [1:0] BLOB_Y_LO = 2'd1;
    localparam logic [1:0] BLOB_HI   = 2'd2;

    // Field slices of the third record byte: {Y[9:8], X[9:8], S[3:0]}
    localparam int HI_Y_MSB = 7;
    localparam int HI_Y_LSB = 6;
    localparam int HI_X_MSB = 5;
    localparam int HI_X_LSB = 4;
    localparam int HI_S_MSB = 3;
    localparam int HI_S_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } state_e;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] s;
        logic       valid;
    } blob_t;

    function automatic logic blob_is_valid(input logic [9:0] x, input logic [9:0] y);
        return !((x == INVALID_COORD) && (y == INVALID_COORD));
    endfunction

endpackage

// File: rtl/ir_blob_decoder_blob_assembler.sv
// Collects the three bytes of one extended-mode blob record; the decoded blob is
// presented combinationally in the same cycle as the record's last byte.
module blob_assembler
    import ir_blob_decoder_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] byte_i,
    input  logic       accept_i,
    input  logic [1:0] pos_i,
    output logic       blob_done_o,
    output blob_t      blob_o
);

    logic [7:0] b0_q;
    logic [7:0] b1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b0_q <= '0;
            b1_q <= '0;
        end else if (accept_i) begin
            if (pos_i == BLOB_X_LO) b0_q <= byte_i;
            if (pos_i == BLOB_Y_LO) b1_q <= byte_i;
        end
    end

    always_comb begin
        blob_done_o  = accept_i && (pos_i == BLOB_HI);
        blob_o.x     = {byte_i[HI_X_MSB:HI_X_LSB], b0_q};
        blob_o.y     = {byte_i[HI_Y_MSB:HI_Y_LSB], b1_q};
        blob_o.s     = byte_i[HI_S_MSB:HI_S_LSB];
        blob_o.valid = blob_is_valid(blob_o.x, blob_o.y);
    end

endmodule

// File: rtl/ir_blob_decoder.sv
// Frame-level decoder: tracks byte position, keeps the largest valid blob of the
// frame and publishes it with a one-cycle strobe; aborts on restart or idle gap.
//
// state      | meaning
// ST_IDLE    | waiting for a byte flagged as first of frame
// ST_COLLECT | consuming header and blob record bytes
// ST_PUBLISH | one cycle: xy_valid_o high, outputs hold the new frame's result
module ir_blob_decoder
    import ir_blob_decoder_pkg::*;
#(
    parameter int NUM_BLOBS    = 4,
    parameter int HEADER_BYTES = 1,
    parameter int TIMEOUT      = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    input  logic        byte_first_i,
    output logic [10:0] x_o,
    output logic [10:0] y_o,
    output logic [3:0]  size_o,
    output logic        found_o,
    output logic [2:0]  blob_count_o,
    output logic        xy_valid_o,
    output logic        frame_error_o
);

    localparam int FRAME_LEN = HEADER_BYTES + 3 * NUM_BLOBS;
    localparam int IW        = $clog2(FRAME_LEN + 1);
    localparam int TW        = $clog2(TIMEOUT);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, cur_idx;
    logic [1:0]      pos_q, cur_pos, next_pos;
    logic [TW-1:0]   tmr_q;
    logic [2:0]      acc_q, acc_base, acc_d;
    logic            have_q, have_base, have_d;
    logic [9:0]      bx_q, by_q, bx_d, by_d;
    logic [3:0]      bs_q, bs_d;
    logic            err_q;
    logic [10:0]     x_q, y_q;
    logic [3:0]      size_q;
    logic            found_q;
    logic [2:0]      blob_count_q;

    logic            start, in_collect, take, is_data, last, restart_err, timeout;
    logic            blob_done;
    blob_t           blob;

    // A flagged first byte always starts a frame at index 0, whatever the state.
    assign start       = byte_valid_i && byte_first_i;
    assign in_collect  = (state_q == ST_COLLECT);
    assign take        = start || (in_collect && byte_valid_i);
    assign cur_idx     = start ? '0 : idx_q;
    assign cur_pos     = start ? BLOB_X_LO : pos_q;
    assign next_pos    = (cur_pos == BLOB_HI) ? BLOB_X_LO : cur_pos + 2'd1;
    assign is_data     = (cur_idx >= IW'(HEADER_BYTES));
    assign last        = take && (cur_idx == IW'(FRAME_LEN - 1));
    assign restart_err = start && in_collect;
    assign timeout     = in_collect && !byte_valid_i && (tmr_q == TW'(1));

    blob_assembler u_blob_assembler (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .byte_i      (byte_data_i),
        .accept_i    (take && is_data),
        .pos_i       (cur_pos),
        .blob_done_o (blob_done),
        .blob_o      (blob)
    );

    always_comb begin
        acc_base  = start ? '0 : acc_q;
        have_base = start ? 1'b0 : have_q;
        acc_d     = acc_base;
        have_d    = have_base;
        bx_d      = bx_q;
        by_d      = by_q;
        bs_d      = bs_q;
        // Strict compare: on equal size the earlier blob stays selected.
        if (blob_done && blob.valid) begin
            acc_d = acc_base + 3'd1;
            if (!have_base || (blob.s > bs_q)) begin
                have_d = 1'b1;
                bx_d   = blob.x;
                by_d   = blob.y;
                bs_d   = blob.s;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_COLLECT;
            ST_COLLECT: begin
                if (last)         state_d = ST_PUBLISH;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_PUBLISH: state_d = start ? ST_COLLECT : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        xy_valid_o    = (state_q == ST_PUBLISH);
        frame_error_o = err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q        <= '0;
            pos_q        <= BLOB_X_LO;
            tmr_q        <= '0;
            acc_q        <= '0;
            have_q       <= 1'b0;
            bx_q         <= '0;
            by_q         <= '0;
            bs_q         <= '0;
            err_q        <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            size_q       <= '0;
            found_q      <= 1'b0;
            blob_count_q <= '0;
        end else begin
            err_q <= restart_err || timeout;
            if (take) begin
                tmr_q <= TW'(TIMEOUT - 1);
                if (last) begin
                    idx_q  <= '0;
                    pos_q  <= BLOB_X_LO;
                    acc_q  <= '0;
                    have_q <= 1'b0;
                end else begin
                    idx_q  <= cur_idx + IW'(1);
                    pos_q  <= is_data ? next_pos : cur_pos;
                    acc_q  <= acc_d;
                    have_q <= have_d;
                end
                bx_q <= bx_d;
                by_q <= by_d;
                bs_q <= bs_d;
            end else if (in_collect) begin
                tmr_q <= tmr_q - TW'(1);
                if (timeout) begin
                    idx_q  <= '0;
                    pos_q  <= BLOB_X_LO;
                    acc_q  <= '0;
                    have_q <= 1'b0;
                end
            end
            if (last) begin
                blob_count_q <= acc_d;
                found_q      <= (acc_d != 3'd0);
                if (acc_d != 3'd0) begin
                    x_q    <= {1'b0, bx_d};
                    y_q    <= {1'b0, by_d};
                    size_q <= bs_d;
                end
            end
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign size_o       = size_q;
    assign found_o      = found_q;
    assign blob_count_o = blob_count_q;

endmodule

// File: doc/ir_blob_decoder.md
Name: ir_blob_decoder

Overview:
- Consumes the byte stream read back from the IR camera by the I2C camera reader.
- Unpacks each frame (header plus NUM_BLOBS 3-byte extended-mode blob records) into blob coordinates.
- Selects the largest valid blob and publishes its x/y/size to the downstream xy consumer (LED/position logic) with a one-cycle strobe.
- Sits between the camera block and xy_leds.

Parameters:
- NUM_BLOBS, 4, blob records per frame (1..4).
- HEADER_BYTES, 1, leading bytes per frame that are discarded.
- TIMEOUT, 4096, max clk cycles between bytes inside a frame before abort (>=2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- byte_data  in  8  byte from camera reader.
- byte_valid  in  1  byte_data valid this cycle (single-cycle strobe per byte).
- byte_first  in  1  qualifies byte_valid: byte is first of a new frame.
- x  out  11  selected blob X, zero-extended from 10 bits.
- y  out  11  selected blob Y, zero-extended from 10 bits.
- size  out  4  selected blob size.
- found  out  1  last completed frame had >=1 valid blob.
- blob_count  out  3  number of valid blobs in last completed frame.
- xy_valid  out  1  one-cycle pulse: outputs updated.
- frame_error  out  1  one-cycle pulse: frame aborted.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, byte index 0, best-blob registers cleared.
- FRAME_LEN = HEADER_BYTES + 3*NUM_BLOBS; byte index counts 0..FRAME_LEN-1.
- Blob record byte order: b0 = X[7:0], b1 = Y[7:0], b2 = {Y[9:8], X[9:8], S[3:0]}.
- A blob is invalid iff X10 == 10'h3FF and Y10 == 10'h3FF.
- States:
  - IDLE: byte_valid & byte_first -> take byte as index 0, go to COLLECT. byte_valid without byte_first is ignored.
  - COLLECT: on each byte_valid, increment index; bytes below HEADER_BYTES are discarded. On each blob's b2:
    - if valid, blob_count_acc++;
    - if valid and (no best yet or S > best_size), latch it as best. Ties keep the lower blob index.
    - After index FRAME_LEN-1 -> PUBLISH.
  - PUBLISH (1 cycle):
    - blob_count <= acc; found <= (acc != 0); xy_valid = 1.
    - x/y/size updated only if acc != 0, otherwise previous values held.
    - Clear accumulators, go to IDLE.
    - A byte_valid & byte_first in this cycle is handled as in IDLE (starts the next frame; no byte lost).
- Latency: xy_valid asserts the cycle after the clock edge that captures the last byte.
- Errors (each pulses frame_error one cycle; x/y/size/found/blob_count unchanged):
  - byte_first with byte_valid in COLLECT: abort the partial frame and restart with this byte as index 0 (stay in COLLECT).
  - Idle-gap counter in COLLECT, cleared on every byte_valid: reaching TIMEOUT-1 -> abort, go to IDLE.
- byte_valid low in COLLECT simply stalls; there is no per-frame length limit other than TIMEOUT.
- xy_valid and frame_error are never high in the same cycle.
- Reset asserted mid-frame: immediate return to reset values; no pulse is generated.

Decomposition:
- Shared package (camera_pkg): INVALID_COORD = 10'h3FF; blob byte offsets (BLOB_X_LO=0, BLOB_Y_LO=1, BLOB_HI=2); state encoding (IDLE/COLLECT/PUBLISH); blob record field slices of b2.
- One sub-module, blob_assembler:
  - takes byte/valid/position-in-record inputs;
  - registers b0 and b1;
  - on b2 emits a one-cycle blob_done with x10, y10, s4 and valid.
- Top level holds the FSM, counters, best-blob compare and the output registers.

Test Plan:
- Basic frame: header 0x00, blob0 = 34,78,65, blobs1-3 = FF,FF,FF -> one cycle after last byte: xy_valid=1, x=564, y=376, size=5, found=1, blob_count=1.
- Largest select and tie: sizes 3,9,9,2 at distinct coords, all valid -> blob1 coords reported, size=9, blob_count=4.
- All invalid: every record FF,FF,FF after a good frame -> xy_valid pulse, found=0, blob_count=0, x/y/size still hold the previous frame's values.
- Restart mid-frame: byte_first arrives at index 5 -> frame_error pulse, no xy_valid; the following complete 13-byte frame publishes normally.
- Timeout: stop after 7 bytes, wait TIMEOUT cycles -> single frame_error pulse, state IDLE, outputs unchanged; next frame decodes correctly.
- Reset: assert reset mid-COLLECT and during PUBLISH -> outputs 0 immediately, no pulses; back-to-back frames, with byte_first in the PUBLISH cycle, decode without loss.
